// File: rtl/lif_array_if.sv
// Step, current, probe-select and spike/probe result signals of the LIF neuron array.
interface lif_array_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    logic              step_i;
    logic [N*W-1:0]    current_i;
    logic [PW-1:0]     probe_sel_i;
    logic [N-1:0]      spikes_o;
    logic              spike_valid_o;
    logic [CW-1:0]     spike_count_o;
    logic [W-1:0]      probe_v_o;
    logic [W-1:0]      probe_thr_o;

    modport master (
        output step_i, current_i, probe_sel_i,
        input  spikes_o, spike_valid_o, spike_count_o, probe_v_o, probe_thr_o
    );

    modport slave (
        input  step_i, current_i, probe_sel_i,
        output spikes_o, spike_valid_o, spike_count_o, probe_v_o, probe_thr_o
    );
endinterface

// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons advanced by step_i; spikes are registered one cycle after a step.
// No backpressure: every step strobe is accepted, so holding step_i high updates the array every cycle.
module lif_array #(
    parameter int N               = 4,
    parameter int W               = 8,
    parameter int THRESHOLD       = 32,
    parameter int THRESHOLD_INC   = 2,
    parameter int THRESHOLD_DEC   = 1,
    parameter int THRESHOLD_MIN   = 16,
    parameter int THRESHOLD_MAX   = 2**W - 1,
    parameter int LEAK_SHIFT_IN   = 1,
    parameter int LEAK_SHIFT_IDLE = 3,
    parameter int REFRACTORY      = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    lif_array_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic [W-1:0]  L_THR   = W'(THRESHOLD);
    localparam logic [W-1:0]  L_MIN   = W'(THRESHOLD_MIN);
    localparam logic [W-1:0]  L_DEC   = W'(THRESHOLD_DEC);
    localparam logic [W:0]    L_INC   = (W+1)'(THRESHOLD_INC);
    localparam logic [W:0]    L_MAX   = (W+1)'(THRESHOLD_MAX);
    localparam logic [W:0]    L_FLOOR = (W+1)'(THRESHOLD_MIN + THRESHOLD_DEC);
    localparam logic [RW-1:0] L_REFR  = RW'(REFRACTORY);

    generate
        if (N < 1 || THRESHOLD_MIN > THRESHOLD || THRESHOLD > THRESHOLD_MAX
            || THRESHOLD_MAX >= 2**W) begin : g_bad_params
            $error("lif_array: illegal parameter combination");
        end
    endgenerate

    logic [W-1:0]  r_v    [N];
    logic [W-1:0]  r_thr  [N];
    logic [RW-1:0] r_refr [N];
    logic [N-1:0]  r_spikes;
    logic          r_vld;
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  w_cur      [N];
    logic [W:0]    w_sum      [N];
    logic [W:0]    w_thr_inc  [N];
    logic [W-1:0]  w_vp       [N];
    logic [W-1:0]  w_v_nxt    [N];
    logic [W-1:0]  w_thr_nxt  [N];
    logic [RW-1:0] w_refr_nxt [N];
    logic [N-1:0]  w_spk;
    logic [CW-1:0] w_cnt;

    always_comb begin
        w_spk = '0;
        for (int k = 0; k < N; k++) begin
            w_cur[k]      = bus.current_i[k*W +: W];
            w_sum[k]      = {1'b0, w_cur[k]} + ({1'b0, r_v[k]} >> LEAK_SHIFT_IN);
            w_thr_inc[k]  = {1'b0, r_thr[k]} + L_INC;
            w_vp[k]       = r_v[k] - (r_v[k] >> LEAK_SHIFT_IDLE);
            w_v_nxt[k]    = r_v[k];
            w_thr_nxt[k]  = r_thr[k];
            w_refr_nxt[k] = r_refr[k];

            if (w_cur[k] != '0) begin
                w_vp[k] = w_sum[k][W] ? '1 : w_sum[k][W-1:0];
            end

            // A refractory neuron is clamped at rest and never fires.
            if (r_refr[k] != '0) begin
                w_refr_nxt[k] = r_refr[k] - 1'b1;
                w_v_nxt[k]    = '0;
            end else if (w_vp[k] >= r_thr[k]) begin
                w_spk[k]      = 1'b1;
                w_refr_nxt[k] = L_REFR;
                w_v_nxt[k]    = '0;
            end else begin
                w_v_nxt[k]    = w_vp[k];
            end

            if (w_spk[k]) begin
                w_thr_nxt[k] = (w_thr_inc[k] > L_MAX) ? L_MAX[W-1:0] : w_thr_inc[k][W-1:0];
            end else if (r_thr[k] > L_MIN) begin
                w_thr_nxt[k] = ({1'b0, r_thr[k]} >= L_FLOOR) ? (r_thr[k] - L_DEC) : L_MIN;
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < N; k++) begin
            w_cnt = w_cnt + CW'(w_spk[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                r_v[k]    <= '0;
                r_thr[k]  <= L_THR;
                r_refr[k] <= '0;
            end
            r_spikes <= '0;
            r_vld    <= 1'b0;
            r_cnt    <= '0;
        end else if (bus.step_i) begin
            for (int k = 0; k < N; k++) begin
                r_v[k]    <= w_v_nxt[k];
                r_thr[k]  <= w_thr_nxt[k];
                r_refr[k] <= w_refr_nxt[k];
            end
            r_spikes <= w_spk;
            r_vld    <= 1'b1;
            r_cnt    <= w_cnt;
        end else begin
            r_vld    <= 1'b0;
        end
    end

    logic w_sel_ok;
    assign w_sel_ok = ({1'b0, bus.probe_sel_i} < (PW+1)'(N));

    assign bus.spikes_o      = r_spikes;
    assign bus.spike_valid_o = r_vld;
    assign bus.spike_count_o = r_cnt;
    assign bus.probe_v_o     = w_sel_ok ? r_v[bus.probe_sel_i]   : '0;
    assign bus.probe_thr_o   = w_sel_ok ? r_thr[bus.probe_sel_i] : '0;
endmodule

// File: doc/lif_array.md
# lif_array

Parametrised array of N leaky integrate-and-fire neurons. Each neuron has its own membrane state, adaptive threshold and refractory counter, and all neurons advance together on an explicit time-step strobe. The array feeds the spike-routing and readout logic downstream. Relative to the single-neuron LIF, it adds configurable width, configurable leak shifts, saturating arithmetic, a threshold ceiling, a refractory period, a step strobe with a valid pulse, a spike population count and a membrane debug probe.

## Interface
- N, 4, number of neurons
- W, 8, width of current, membrane and threshold
- THRESHOLD, 32, threshold reset value
- THRESHOLD_INC, 2, threshold increment on spike
- THRESHOLD_DEC, 1, threshold decrement on a non-spike step
- THRESHOLD_MIN, 16, threshold floor
- THRESHOLD_MAX, 2^W-1, threshold ceiling
- LEAK_SHIFT_IN, 1, membrane decay shift when input is nonzero
- LEAK_SHIFT_IDLE, 3, membrane decay shift when input is zero
- REFRACTORY, 2, number of steps a neuron is held after it spikes; 0 disables the refractory period
- clk_i  in  1  clock; one clock domain, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- step_i  in  1  time-step strobe; one update per high cycle
- current_i  in  N*W  per-neuron input current; neuron k occupies bits [k*W +: W]
- probe_sel_i  in  clog2(N)  neuron selected for the probe outputs
- spikes_o  out  N  spike vector from the last step
- spike_valid_o  out  1  one-cycle pulse marking a new spikes_o value
- spike_count_o  out  clog2(N+1)  popcount of spikes_o
- probe_v_o  out  W  membrane of the selected neuron (combinational read)
- probe_thr_o  out  W  threshold of the selected neuron (combinational read)

## Operation
- Per-neuron state: v_k (W bits), thr_k (W bits), refr_k (clog2(REFRACTORY+1) bits).
- Reset values: v_k=0, thr_k=THRESHOLD, refr_k=0, spikes_o=0, spike_valid_o=0, spike_count_o=0.
- While step_i=0, all state and spikes_o hold, and spike_valid_o=0.
- On a step, each neuron k updates independently:
  - Refractory case (refr_k>0): refr_k decrements; v_k stays 0; spike_k=0.
  - Otherwise, compute the next membrane value v':
    - If current_k≠0: v' = min(current_k + (v_k>>LEAK_SHIFT_IN), 2^W-1). The sum is computed at W+1 bits, then saturated.
    - If current_k=0: v' = v_k − (v_k>>LEAK_SHIFT_IDLE). When v_k < 2^LEAK_SHIFT_IDLE, no decay occurs.
  - Spike rule: spike_k = (v' ≥ thr_k), compared against the pre-step thr_k.
    - On a spike: v_k←0 and refr_k←REFRACTORY.
    - Otherwise: v_k←v'.
  - Threshold update, same step:
    - On a spike: thr_k ← min(thr_k+THRESHOLD_INC, THRESHOLD_MAX).
    - Otherwise, if thr_k>THRESHOLD_MIN: thr_k ← max(thr_k−THRESHOLD_DEC, THRESHOLD_MIN). Otherwise thr_k holds.
    - thr_k also decays during refractory steps.
- Registered outputs on each step: spikes_o←{spike_k}, spike_count_o←popcount, spike_valid_o←1.
- Parameter legality: THRESHOLD_MIN ≤ THRESHOLD ≤ THRESHOLD_MAX < 2^W, and N ≥ 1. Violations are caught by an elaboration-time check.

## Timing
- Latency: a step at cycle t is visible on spikes_o, spike_count_o and spike_valid_o at cycle t+1.
- spike_valid_o is high for exactly one cycle per step.
- Back-to-back steps (step_i held high) update every cycle, giving full throughput with no bubbles.
- current_i is sampled only in cycles where step_i=1.
- Probe outputs reflect the registered state. After a step at cycle t, they show updated values from cycle t+1.
- Reset dominates step_i. If rst_i=1 in a step cycle, the step is discarded and every register takes its reset value at the next edge.
- Reset asserted mid-refractory clears refr_k to 0.

## Test plan
- Reset: hold rst_i 2 cycles, then release. Required: spikes_o=0, spike_count_o=0, spike_valid_o=0, probe_thr_o=32 and probe_v_o=0 for every probe_sel_i.
- Integrate and refractory, defaults, neuron 0, current 20 held, step every cycle:
  - v sequence 20, 30, then spike on step 3 (v'=35 ≥ thr 30), with spikes_o=0001 and count=1 at step 3 + 1 cycle.
  - thr goes 32→31→30→32.
  - Steps 4–5 are refractory: v=0, thr 31, 30.
  - Step 6: v=20.
- Idle leak and threshold floor, neuron 2: current 20 for 2 steps (v=30), then 0.
  - v goes 27, 24, 21, ...
  - No spike occurs.
  - thr reaches 16 and stays at 16 on all further steps.
- Saturation, with THRESHOLD=THRESHOLD_MIN=THRESHOLD_MAX=255 and current 200:
  - Step 1: v=200, no spike.
  - Step 2: sum 300 saturates to 255, so spike fires; thr stays 255.
- Stall and population count:
  - step_i low for 10 cycles. Required: state, spikes_o and probes unchanged, spike_valid_o=0.
  - Then all four neurons get current 255 in one step. Required: spikes_o=1111, spike_count_o=4, and a single spike_valid_o pulse.
- Reset mid-operation: assert rst_i in the same cycle as step_i while a neuron is refractory. Required: the step is ignored, all values are at reset the next cycle, and the neuron integrates again on the next step.
